// File: rtl/vga_bus_reader.sv
// CPU-side read path of the VGA register block: synchronised 6502 bus decode, read hold
// register, and a one-byte framebuffer prefetch. Optional: VGA_INTR_READ_CLEAR_EN.
module vga_bus_reader (
  input  logic        i_clk_fast,
  input  logic        i_reset_n,
  input  logic        i_clk_cpu,
  input  logic        i_en,
  input  logic        i_rw,
  input  logic [2:0]  i_reg,
  output logic [7:0]  o_data_out,
  output logic        o_data_oe,
  output logic        o_dir,
  input  logic [13:0] i_addr,
  input  logic        i_addr_load,
  input  logic [7:0]  i_ctrl,
  input  logic [7:0]  i_ien,
  input  logic [7:0]  i_intr,
  input  logic [7:0]  i_hscroll,
  input  logic [7:0]  i_vscroll,
  input  logic [7:0]  i_bgcolor,
  input  logic [7:0]  i_fgcolor,
  output logic [12:0] o_fb_addr,
  output logic        o_fb_rd,
  input  logic [7:0]  i_fb_data,
  output logic        o_adv,
  output logic [7:0]  o_intr_clr,
  output logic        o_rd_miss
);

  typedef enum logic [1:0] {PF_IDLE, PF_WAIT1, PF_WAIT2, PF_READY} pf_state_t;

  pf_state_t   r_pf_state;
  pf_state_t   w_pf_next;
  logic [7:0]  r_pf;
  logic [7:0]  w_pf_data_next;
  logic [12:0] r_fb_addr;
  logic [5:0]  r_sync1;
  logic [5:0]  r_sync2;
  logic        r_in_read;
  logic        r_oe;
  logic        r_end_d;
  logic        r_hit;
  logic        r_adv;
  logic        r_rd_miss;
  logic [7:0]  r_hold;
  logic [7:0]  w_sel;
  logic        w_cpu;
  logic        w_en_n;
  logic        w_rw;
  logic [2:0]  w_reg;
  logic        w_start;
  logic        w_read_end;
  logic        w_pf_valid;
  logic        w_miss;
  logic        w_consume;

  always_ff @(posedge i_clk_fast) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_clk_cpu, i_en, i_rw, i_reg};
      r_sync2 <= r_sync1;
    end
  end

  assign w_cpu      = r_sync2[5];
  assign w_en_n     = r_sync2[4];
  assign w_rw       = r_sync2[3];
  assign w_reg      = r_sync2[2:0];
  assign w_pf_valid = (r_pf_state == PF_READY);
  // r_in_read stays set until phi2 falls, so only one start per high phase
  assign w_start    = w_cpu && !w_en_n && w_rw && !r_in_read;
  assign w_read_end = r_in_read && !w_cpu;
  assign w_miss     = w_start && (w_reg == 3'd3) && !w_pf_valid;
  assign w_consume  = w_read_end && r_hit;

  always_comb begin
    w_sel = 8'h00;
    case (w_reg)
      3'd0: w_sel = i_ctrl;
      3'd1: w_sel = {2'b00, i_addr[5:0]};
      3'd2: w_sel = i_addr[13:6];
      3'd3: w_sel = w_pf_valid ? r_pf : 8'hFF;
      3'd4: w_sel = i_ien;
      3'd5: w_sel = i_intr;
      3'd6: w_sel = i_hscroll;
      default: w_sel = i_vscroll;
    endcase
  end

  always_ff @(posedge i_clk_fast) begin
    if (!i_reset_n) begin
      r_in_read <= 1'b0;
      r_oe      <= 1'b0;
      r_end_d   <= 1'b0;
      r_hit     <= 1'b0;
      r_adv     <= 1'b0;
      r_rd_miss <= 1'b0;
      r_hold    <= 8'h00;
    end else begin
      r_rd_miss <= w_miss;
      r_adv     <= w_consume;
      r_end_d   <= w_read_end;
      if (w_start) begin
        r_in_read <= 1'b1;
        r_oe      <= 1'b1;
        r_hold    <= w_sel;
        r_hit     <= (w_reg == 3'd3) && w_pf_valid;
      end else if (w_read_end) begin
        r_in_read <= 1'b0;
        r_hit     <= 1'b0;
      end else if (r_end_d) begin
        r_oe      <= 1'b0;
      end
    end
  end

  assign o_data_oe  = r_oe;
  assign o_dir      = !r_oe;
  assign o_data_out = r_oe ? r_hold : 8'h00;
  assign o_adv      = r_adv;
  assign o_rd_miss  = r_rd_miss;

`ifdef VGA_INTR_READ_CLEAR_EN
  logic       r_is_intr;
  logic [7:0] r_intr_clr;

  always_ff @(posedge i_clk_fast) begin
    if (!i_reset_n) begin
      r_is_intr  <= 1'b0;
      r_intr_clr <= 8'h00;
    end else begin
      r_intr_clr <= (w_read_end && r_is_intr) ? r_hold : 8'h00;
      if (w_start)
        r_is_intr <= (w_reg == 3'd5);
      else if (w_read_end)
        r_is_intr <= 1'b0;
    end
  end

  assign o_intr_clr = r_intr_clr;
`else
  assign o_intr_clr = 8'h00;
`endif

  always_ff @(posedge i_clk_fast) begin
    if (!i_reset_n) begin
      r_pf_state <= PF_IDLE;
      r_pf       <= 8'h00;
      r_fb_addr  <= 13'h0000;
    end else begin
      r_pf_state <= w_pf_next;
      r_pf       <= w_pf_data_next;
      if (o_fb_rd)
        r_fb_addr <= o_fb_addr;
    end
  end

  // FB_RD is issued in the ADDR_LOAD cycle so the byte arrives during PF_WAIT2
  always_comb begin
    w_pf_next      = r_pf_state;
    w_pf_data_next = r_pf;
    o_fb_rd        = 1'b0;
    o_fb_addr      = r_fb_addr;
    if (i_reset_n && i_addr_load) begin
      if (i_addr < 14'h17FE) begin
        w_pf_next = PF_WAIT1;
        o_fb_rd   = 1'b1;
        o_fb_addr = i_addr[12:0];
      end else begin
        w_pf_next = PF_READY;
        if (i_addr == 14'h17FE)
          w_pf_data_next = i_bgcolor;
        else if (i_addr == 14'h17FF)
          w_pf_data_next = i_fgcolor;
        else
          w_pf_data_next = 8'h00;
      end
    end else begin
      case (r_pf_state)
        PF_WAIT1: w_pf_next = PF_WAIT2;
        PF_WAIT2: begin
          w_pf_next      = PF_READY;
          w_pf_data_next = i_fb_data;
        end
        PF_READY: if (w_consume) w_pf_next = PF_IDLE;
        default:  w_pf_next = r_pf_state;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_bus_reader.sv
// Scoreboarded bench for vga_bus_reader: expected read bytes are queued per access
// and popped when the bus sample is taken; pulse outputs are counted by a monitor.
module tb_vga_bus_reader;

  logic        clk_fast = 1'b0;
  logic        reset_n  = 1'b0;
  logic        clk_cpu  = 1'b0;
  logic        en       = 1'b1;
  logic        rw       = 1'b1;
  logic [2:0]  reg_sel  = 3'd0;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        dir;
  logic [13:0] addr      = 14'h0000;
  logic        addr_load = 1'b0;
  logic [7:0]  ctrl = 8'h5A, ien = 8'hA5, intr = 8'h00, hscroll = 8'h12, vscroll = 8'h34;
  logic [7:0]  bgcolor = 8'h00, fgcolor = 8'h00;
  logic [12:0] fb_addr;
  logic        fb_rd;
  logic [7:0]  fb_data;
  logic        adv;
  logic [7:0]  intr_clr;
  logic        rd_miss;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  int adv_cnt = 0, miss_cnt = 0, fbrd_cnt = 0, intr_cnt = 0;
  logic [7:0] intr_val = 8'h00;
  logic [7:0] r_p1 = 8'hEE, r_p2 = 8'hEE;

  vga_bus_reader dut (
    .i_clk_fast(clk_fast), .i_reset_n(reset_n), .i_clk_cpu(clk_cpu), .i_en(en),
    .i_rw(rw), .i_reg(reg_sel), .o_data_out(data_out), .o_data_oe(data_oe),
    .o_dir(dir), .i_addr(addr), .i_addr_load(addr_load), .i_ctrl(ctrl), .i_ien(ien),
    .i_intr(intr), .i_hscroll(hscroll), .i_vscroll(vscroll), .i_bgcolor(bgcolor),
    .i_fgcolor(fgcolor), .o_fb_addr(fb_addr), .o_fb_rd(fb_rd), .i_fb_data(fb_data),
    .o_adv(adv), .o_intr_clr(intr_clr), .o_rd_miss(rd_miss)
  );

  always #5 clk_fast = ~clk_fast;

  function automatic logic [7:0] fb_byte(input logic [12:0] a);
    return a[7:0] ^ 8'h51;
  endfunction

  // Framebuffer: data valid exactly two cycles after FB_RD, garbage otherwise
  always @(posedge clk_fast) begin
    r_p1 <= fb_rd ? fb_byte(fb_addr) : 8'hEE;
    r_p2 <= r_p1;
  end
  assign fb_data = r_p2;

  always @(negedge clk_fast) begin
    if (adv) adv_cnt++;
    if (rd_miss) miss_cnt++;
    if (fb_rd) fbrd_cnt++;
    if (intr_clr != 8'h00) begin
      intr_cnt++;
      intr_val = intr_clr;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_fast);
      #1;
    end
  endtask

  task automatic load_addr(input logic [13:0] a);
    addr = a;
    addr_load = 1'b1;
    tick(1);
    addr_load = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] r, input logic [7:0] exp,
                          output logic [7:0] d, output logic oe, output logic dr,
                          output int adv_mid);
    exp_q.push_back(exp);
    en = 1'b0; rw = 1'b1; reg_sel = r; clk_cpu = 1'b1;
    tick(6);
    d = data_out; oe = data_oe; dr = dir; adv_mid = adv_cnt;
    clk_cpu = 1'b0;
    tick(6);
    en = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({data_out, data_oe, dir, fb_rd, fb_addr, adv, intr_clr, rd_miss} !==
        {8'h00, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got data=%h oe=%b dir=%b fb_rd=%b fb_addr=%h adv=%b iclr=%h miss=%b",
               data_out, data_oe, dir, fb_rd, fb_addr, adv, intr_clr, rd_miss);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_miss();
    logic [7:0] d, e; logic oe, dr; int am;
    int a0 = adv_cnt, m0 = miss_cnt;
    bus_read(3'd3, 8'hFF, d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e || oe !== 1'b1) begin
      failures++; $display("FAIL miss_data got=%h oe=%b exp=%h oe=1", d, oe, e);
    end
    checks++;
    if (miss_cnt - m0 != 1 || adv_cnt != a0) begin
      failures++; $display("FAIL miss_pulses got miss=%0d adv=%0d exp miss=1 adv=0", miss_cnt - m0, adv_cnt - a0);
    end
  endtask

  task automatic test_prefetch();
    logic [7:0] d, e; logic oe, dr; int am;
    int a0 = adv_cnt;
    load_addr(14'h0010);
    tick(5);
    bus_read(3'd3, 8'h41, d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e || dr !== 1'b0) begin
      failures++; $display("FAIL prefetch_data got=%h dir=%b exp=%h dir=0", d, dr, e);
    end
    checks++;
    if (am != a0 || adv_cnt - a0 != 1) begin
      failures++; $display("FAIL prefetch_adv got before_fall=%0d total=%0d exp 0 and 1", am - a0, adv_cnt - a0);
    end
    bus_read(3'd3, 8'hFF, d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e || adv_cnt - a0 != 1) begin
      failures++; $display("FAIL prefetch_consumed got=%h adv=%0d exp=%h adv=1", d, adv_cnt - a0, e);
    end
  endtask

  task automatic test_restart();
    logic [7:0] d, e; logic oe, dr; int am;
    load_addr(14'h0020);
    load_addr(14'h0030);
    tick(5);
    bus_read(3'd3, fb_byte(13'h0030), d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++; $display("FAIL restart_wait1 got=%h exp=%h", d, e);
    end
    load_addr(14'h0040);
    tick(1);
    load_addr(14'h0050);
    tick(5);
    bus_read(3'd3, fb_byte(13'h0050), d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++; $display("FAIL restart_wait2 got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_color();
    logic [7:0] d, e; logic oe, dr; int am;
    int f0 = fbrd_cnt;
    logic [13:0] ad[3] = '{14'h17FE, 14'h17FF, 14'h1900};
    logic [7:0]  ex[3] = '{8'hE3, 8'h1C, 8'h00};
    bgcolor = 8'hE3; fgcolor = 8'h1C;
    for (int i = 0; i < 3; i++) begin
      load_addr(ad[i]);
      tick(2);
      bus_read(3'd3, ex[i], d, oe, dr, am);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        failures++; $display("FAIL color_%0d got=%h exp=%h", i, d, e);
      end
    end
    checks++;
    if (fbrd_cnt != f0) begin
      failures++; $display("FAIL color_fb_rd got=%0d exp=0", fbrd_cnt - f0);
    end
  endtask

  task automatic test_regs();
    logic [7:0] d, e; logic oe, dr; int am;
    int a0 = adv_cnt, i0 = intr_cnt;
    logic [2:0] rs[6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
    logic [7:0] ex[6] = '{8'h5A, 8'h3C, 8'hAA, 8'hA5, 8'h12, 8'h34};
    addr = 14'h2ABC;
    for (int i = 0; i < 6; i++) begin
      bus_read(rs[i], ex[i], d, oe, dr, am);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        failures++; $display("FAIL reg_%0d got=%h exp=%h", rs[i], d, e);
      end
    end
    checks++;
    if (adv_cnt != a0 || intr_cnt != i0) begin
      failures++; $display("FAIL regs_side_effects got adv=%0d iclr=%0d exp 0 0", adv_cnt - a0, intr_cnt - i0);
    end
  endtask

  task automatic test_intr();
    logic [7:0] d, e; logic oe, dr; int am;
    int i0 = intr_cnt;
    intr = 8'h81;
    bus_read(3'd5, 8'h81, d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++; $display("FAIL intr_data got=%h exp=%h", d, e);
    end
`ifdef VGA_INTR_READ_CLEAR_EN
    checks++;
    if (intr_cnt - i0 != 1 || intr_val !== 8'h81) begin
      failures++; $display("FAIL intr_clr got cycles=%0d val=%h exp 1 81", intr_cnt - i0, intr_val);
    end
`else
    checks++;
    if (intr_cnt != i0) begin
      failures++; $display("FAIL intr_clr got cycles=%0d exp 0", intr_cnt - i0);
    end
`endif
  endtask

  task automatic test_write();
    logic [7:0] d, e; logic oe, dr; int am;
    int a0 = adv_cnt, m0 = miss_cnt;
    logic oe_w;
    load_addr(14'h0010);
    tick(5);
    en = 1'b0; rw = 1'b0; reg_sel = 3'd3; clk_cpu = 1'b1;
    tick(6);
    oe_w = data_oe;
    clk_cpu = 1'b0;
    tick(6);
    en = 1'b1; rw = 1'b1;
    checks++;
    if (oe_w !== 1'b0 || adv_cnt != a0 || miss_cnt != m0) begin
      failures++; $display("FAIL write_quiet got oe=%b adv=%0d miss=%0d exp 0 0 0", oe_w, adv_cnt - a0, miss_cnt - m0);
    end
    bus_read(3'd3, 8'h41, d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e || adv_cnt - a0 != 1) begin
      failures++; $display("FAIL write_then_read got=%h adv=%0d exp=%h adv=1", d, adv_cnt - a0, e);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d, e; logic oe, dr; int am;
    int a0, f0;
    logic oe_pre;
    load_addr(14'h0010);
    tick(5);
    a0 = adv_cnt;
    en = 1'b0; rw = 1'b1; reg_sel = 3'd3; clk_cpu = 1'b1;
    tick(5);
    oe_pre = data_oe;
    reset_n = 1'b0;
    tick(1);
    checks++;
    if (oe_pre !== 1'b1 || data_oe !== 1'b0 || dir !== 1'b1) begin
      failures++; $display("FAIL reset_release got pre_oe=%b oe=%b dir=%b exp 1 0 1", oe_pre, data_oe, dir);
    end
    clk_cpu = 1'b0;
    tick(4);
    reset_n = 1'b1;
    en = 1'b1;
    f0 = fbrd_cnt;
    tick(6);
    checks++;
    if (adv_cnt != a0 || fbrd_cnt != f0) begin
      failures++; $display("FAIL reset_no_pulse got adv=%0d fb_rd=%0d exp 0 0", adv_cnt - a0, fbrd_cnt - f0);
    end
    bus_read(3'd3, 8'hFF, d, oe, dr, am);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++; $display("FAIL reset_pf_invalid got=%h exp=%h", d, e);
    end
  endtask

  initial begin
    tick(3);
    test_reset();
    test_miss();
    test_prefetch();
    test_restart();
    test_color();
    test_regs();
    test_intr();
    test_write();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_bus_reader.md
VGA_BUS_READER -- requirements
Module: vga_bus_reader

Interface
REQ-001 SHALL: CLK_FAST  input  1  core clock; all state on rising edge.
REQ-002 SHALL: RESET_N  input  1  reset, synchronous, active-low.
REQ-003 SHALL: CLK_CPU  input  1  6502 phi2, asynchronous to CLK_FAST.
REQ-004 SHALL: EN  input  1  chip select, active-low; RW  input  1  1=read; REG  input  3  register select.
REQ-005 SHALL: DATA_OUT  output  8  read data to bus; DATA_OE  output  1  1=drive bus; DIR  output  1  transceiver direction, 0 while driving.
REQ-006 SHALL: ADDR  input  14  current VRAM address from write path; ADDR_LOAD  input  1  one-cycle pulse, ADDR changed.
REQ-007 SHALL: CTRL, IEN, INTR, HSCROLL, VSCROLL, BGCOLOR, FGCOLOR  input  8 each  live register values.
REQ-008 SHALL: FB_ADDR  output  13  framebuffer read address; FB_RD  output  1  read strobe; FB_DATA  input  8  valid exactly 2 cycles after FB_RD.
REQ-009 SHALL: ADV  output  1  one-cycle pulse, request address increment; INTR_CLR  output  8  one-cycle clear mask; RD_MISS  output  1  one-cycle pulse.

Function
REQ-010 SHALL: CLK_CPU, EN, RW, REG pass through 2-flop synchronizers before use.
REQ-011 SHALL: read start = first synced cycle with CLK_CPU=1, EN=0, RW=1; read end = synced CLK_CPU falling edge after a start; one start per bus cycle.
REQ-012 SHALL: on read start, latch REG and the selected value into HOLD; DATA_OE=1 and DIR=0 from the next cycle until the cycle after read end.
REQ-013 SHALL: read map: 0 CTRL; 1 {2'b00,ADDR[5:0]}; 2 ADDR[13:6]; 3 PF byte; 4 IEN; 5 INTR; 6 HSCROLL; 7 VSCROLL.
REQ-014 SHALL: DATA_OUT = HOLD while DATA_OE=1, else 0x00.
REQ-015 SHALL: prefetch FSM states PF_IDLE, PF_WAIT1, PF_WAIT2, PF_READY; PF_VALID=1 only in PF_READY.
REQ-016 SHALL: on ADDR_LOAD: go to PF_WAIT1 with FB_RD=1 and FB_ADDR=ADDR[12:0] when ADDR<0x17FE; else go directly to PF_READY with PF=BGCOLOR (0x17FE), FGCOLOR (0x17FF), 0x00 (>=0x1800).
REQ-017 SHALL: PF_WAIT1 -> PF_WAIT2 -> PF_READY; PF captures FB_DATA on the PF_WAIT2 -> PF_READY transition.
REQ-018 SHALL: ADDR_LOAD in PF_WAIT1/PF_WAIT2 restarts the sequence at the new ADDR; the stale FB_DATA is never captured.
REQ-019 SHALL: REG=3 read start with PF_VALID=0 latches HOLD=0xFF and pulses RD_MISS; no ADV for that access.
REQ-020 SHALL: REG=3 read with PF_VALID=1: ADV pulses once, the cycle after read end; FSM returns to PF_IDLE until the next ADDR_LOAD.
REQ-021 SHALL: REG=5 read: INTR_CLR = the HOLD value for one cycle after read end (see REQ-026).
REQ-022 SHALL: write cycles (RW=0) and deselected cycles produce no ADV, INTR_CLR, RD_MISS or bus drive.
REQ-023 SHALL: at most one of ADV / INTR_CLR is non-zero per bus access; the pulse does not repeat if CLK_CPU stays low.

Reset
REQ-024 SHALL: RESET_N=0 at a clock edge: FSM PF_IDLE, PF_VALID=0, PF=0x00, HOLD=0x00, DATA_OE=0, DIR=1, FB_RD=0, FB_ADDR=0, ADV=0, INTR_CLR=0x00, RD_MISS=0, synchronizers cleared.
REQ-025 SHALL: reset during an active read releases the bus the following cycle; after reset the first prefetch starts only on ADDR_LOAD; a read end in progress at reset issues no side-effect pulse.

Configuration
REQ-026 SHALL: VGA_INTR_READ_CLEAR_EN defined: REG=5 read clears flags per REQ-021; undefined: INTR_CLR is constant 0x00 and INTR reads are side-effect-free.

Verification
REQ-027 SHALL: ADDR=0x0010, ADDR_LOAD, FB holds 0x41 at 0x0010, REG=3 read -> DATA_OUT=0x41, DIR=0, one ADV pulse after phi2 fall.
REQ-028 SHALL: ADDR_LOAD at 0x0020, second ADDR_LOAD at 0x0030 during PF_WAIT1 -> PF holds byte at 0x0030, never 0x0020.
REQ-029 SHALL: ADDR=0x17FE, BGCOLOR=0xE3, REG=3 read -> DATA_OUT=0xE3, FB_RD never asserted; ADDR=0x1900 -> DATA_OUT=0x00.
REQ-030 SHALL: REG=3 read with no prior ADDR_LOAD -> DATA_OUT=0xFF, RD_MISS=1 one cycle, ADV=0.
REQ-031 SHALL: INTR=0x81, REG=5 read -> DATA_OUT=0x81, INTR_CLR=0x81 one cycle with macro; 0x00 without.
REQ-032 SHALL: RESET_N low mid REG=3 read -> DATA_OE=0 next cycle, no ADV, PF_VALID=0.
